// File: rtl/inst_prefetch_buffer.sv
// rtl/inst_prefetch_buffer.sv - instruction prefetch FIFO feeding decode pairs from local store
module inst_prefetch_buffer #(
    parameter int DEPTH = 16
) (
    input  logic         clock,
    input  logic         reset,
    output logic         ls_rd_req,
    output logic [0:14]  ls_rd_addr,
    input  logic         ls_rd_valid,
    input  logic [0:127] ls_rd_data,
    input  logic         stall,
    input  logic         branch_taken,
    input  logic [0:31]  branch_target,
    output logic [0:31]  first_inst,
    output logic [0:31]  second_inst,
    output logic         pair_valid,
    output logic [0:31]  pc_output
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] ISSUE_MAX = (PW+1)'(DEPTH - 4);
    localparam logic [PW:0] PAIR_MIN  = (PW+1)'(2);

    typedef enum logic [1:0] {RUN, WAIT, DISCARD} state_t;

    state_t        state, state_next;
    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] head, tail;
    logic [PW:0]   count, count_next;
    logic [0:31]   fetch_pc, head_pc;
    logic [1:0]    skip;
    logic [2:0]    push_n;
    logic          issue, push, pop;
    logic          unused_target_bits;

    assign unused_target_bits = ^branch_target[30:31];

    // Issuing only at DEPTH-4 or below leaves room for a full quadword response.
    assign issue  = (state == RUN) && !branch_taken && (count <= ISSUE_MAX);
    assign push   = (state == WAIT) && ls_rd_valid && !branch_taken;
    assign pop    = !branch_taken && !stall && (count >= PAIR_MIN);
    assign push_n = 3'd4 - {1'b0, skip};
    assign count_next = count + (push ? (PW+1)'(push_n) : '0) - (pop ? PAIR_MIN : '0);

    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (issue) state_next = WAIT;
            end
            WAIT: begin
                if (ls_rd_valid)       state_next = RUN;
                else if (branch_taken) state_next = DISCARD;
            end
            DISCARD: begin
                if (ls_rd_valid) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= RUN;
        else        state <= state_next;
    end

    // Words before skip belong to the quadword but precede the branch target.
    always_ff @(posedge clock) begin
        if (push) begin
            for (int i = 0; i < 4; i++) begin
                if (i >= int'(skip)) mem[tail + PW'(i) - PW'(skip)] <= ls_rd_data[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= '0;
            head_pc     <= '0;
            skip        <= '0;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
            pair_valid  <= 1'b0;
            ls_rd_req   <= 1'b0;
            ls_rd_addr  <= '0;
            first_inst  <= '0;
            second_inst <= '0;
            pc_output   <= '0;
        end else begin
            ls_rd_req <= issue;
            if (issue) ls_rd_addr <= fetch_pc[17:31];
            if (branch_taken) begin
                head        <= '0;
                tail        <= '0;
                count       <= '0;
                pair_valid  <= 1'b0;
                first_inst  <= '0;
                second_inst <= '0;
                fetch_pc    <= {branch_target[0:27], 4'b0};
                head_pc     <= {branch_target[0:29], 2'b0};
                skip        <= branch_target[28:29];
            end else begin
                count <= count_next;
                if (push) begin
                    tail     <= tail + PW'(push_n);
                    skip     <= '0;
                    fetch_pc <= fetch_pc + 32'd16;
                end
                if (!stall) begin
                    if (pop) begin
                        first_inst  <= mem[head];
                        second_inst <= mem[head + PW'(1)];
                        pc_output   <= head_pc;
                        head_pc     <= head_pc + 32'd8;
                        head        <= head + PW'(2);
                        pair_valid  <= 1'b1;
                    end else begin
                        pair_valid  <= 1'b0;
                        first_inst  <= '0;
                        second_inst <= '0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// tb/tb_inst_prefetch_buffer.sv - directed bench for inst_prefetch_buffer
module tb_inst_prefetch_buffer;
    logic         clock, reset, ls_rd_req, ls_rd_valid, stall, branch_taken, pair_valid;
    logic [0:14]  ls_rd_addr;
    logic [0:127] ls_rd_data, resp_data, man_data;
    logic [0:31]  branch_target, first_inst, second_inst, pc_output;
    logic         resp_en, resp_valid, man_valid, resp_alive;
    logic [31:0]  resp_base;
    int           resp_delay;
    int           n_cmp, n_fail;

    assign ls_rd_valid = resp_valid | man_valid;
    assign ls_rd_data  = man_valid ? man_data : resp_data;

    inst_prefetch_buffer #(.DEPTH(16)) dut (
        .clock(clock), .reset(reset), .ls_rd_req(ls_rd_req), .ls_rd_addr(ls_rd_addr),
        .ls_rd_valid(ls_rd_valid), .ls_rd_data(ls_rd_data), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target), .first_inst(first_inst),
        .second_inst(second_inst), .pair_valid(pair_valid), .pc_output(pc_output)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Local store image: the first quadword holds 0x11111111..0x44444444, all others hold their address.
    function automatic logic [31:0] inst_at(input logic [31:0] a);
        logic [31:0] m = a & 32'h0000_7FFF;
        if (m < 32'd16) return 32'h1111_1111 * ((m >> 2) + 32'd1);
        return m;
    endfunction

    function automatic logic [0:127] quad_at(input logic [31:0] base);
        logic [0:127] q;
        for (int i = 0; i < 4; i++) q[32*i +: 32] = inst_at(base + 32'(4*i));
        return q;
    endfunction

    initial begin
        resp_valid = 1'b0;
        resp_data  = '0;
        forever begin
            @(negedge clock);
            resp_valid = 1'b0;
            if (reset && resp_en && ls_rd_req) begin
                resp_base  = {17'd0, ls_rd_addr};
                resp_alive = 1'b1;
                for (int k = 0; k < resp_delay; k++) begin
                    @(negedge clock);
                    if (!reset) resp_alive = 1'b0;
                end
                if (resp_alive && reset) begin
                    resp_data  = quad_at(resp_base);
                    resp_valid = 1'b1;
                end
            end
        end
    end

    task automatic wait_req(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clock);
            ok = ls_rd_req;
        end
    endtask

    task automatic wait_pair(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clock);
            ok = pair_valid;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        n_cmp++; if (ls_rd_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b want 0", ls_rd_req); end
        n_cmp++; if (ls_rd_addr !== 15'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", ls_rd_addr); end
        n_cmp++; if (pair_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pv: got %0b want 0", pair_valid); end
        n_cmp++; if (first_inst !== 32'h0) begin n_fail++; $display("FAIL reset_first: got %h want 0", first_inst); end
        n_cmp++; if (second_inst !== 32'h0) begin n_fail++; $display("FAIL reset_second: got %h want 0", second_inst); end
        n_cmp++; if (pc_output !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", pc_output); end
    endtask

    task automatic test_fill();
        reset = 1'b1;
        @(negedge clock);
        n_cmp++; if (ls_rd_req !== 1'b1) begin n_fail++; $display("FAIL fill_req0: got %0b want 1", ls_rd_req); end
        n_cmp++; if (ls_rd_addr !== 15'h0) begin n_fail++; $display("FAIL fill_addr0: got %h want 0", ls_rd_addr); end
        @(negedge clock);
        n_cmp++; if (pair_valid !== 1'b0) begin n_fail++; $display("FAIL fill_pv_early: got %0b want 0", pair_valid); end
        @(negedge clock);
        n_cmp++; if ({pair_valid, first_inst, second_inst, pc_output} !== {1'b1, 32'h11111111, 32'h22222222, 32'h0})
            begin n_fail++; $display("FAIL fill_pair0: got %0b %h %h %h want 1 11111111 22222222 0", pair_valid, first_inst, second_inst, pc_output); end
        n_cmp++; if ({ls_rd_req, ls_rd_addr} !== {1'b1, 15'h0010}) begin n_fail++; $display("FAIL fill_req1: got %0b %h want 1 0010", ls_rd_req, ls_rd_addr); end
        @(negedge clock);
        n_cmp++; if ({pair_valid, first_inst, second_inst, pc_output} !== {1'b1, 32'h33333333, 32'h44444444, 32'h8})
            begin n_fail++; $display("FAIL fill_pair1: got %0b %h %h %h want 1 33333333 44444444 8", pair_valid, first_inst, second_inst, pc_output); end
    endtask

    task automatic test_backpressure();
        logic [96:0] held;
        int prev_cnt, cnt, max_cnt, hold_bad, over_req, pairs;
        logic [31:0] exp_pc;
        stall = 1'b1;
        held = {pair_valid, first_inst, second_inst, pc_output};
        prev_cnt = int'(dut.count);
        max_cnt = prev_cnt; hold_bad = 0; over_req = 0;
        repeat (20) begin
            @(negedge clock);
            if ({pair_valid, first_inst, second_inst, pc_output} !== held) hold_bad++;
            if (ls_rd_req && prev_cnt > 12) over_req++;
            cnt = int'(dut.count);
            if (cnt > max_cnt) max_cnt = cnt;
            prev_cnt = cnt;
        end
        n_cmp++; if (hold_bad != 0) begin n_fail++; $display("FAIL bp_hold: got %0d changed cycles want 0", hold_bad); end
        n_cmp++; if (over_req != 0) begin n_fail++; $display("FAIL bp_req_over12: got %0d requests want 0", over_req); end
        n_cmp++; if (max_cnt > 16) begin n_fail++; $display("FAIL bp_count_max: got %0d want <=16", max_cnt); end
        n_cmp++; if (prev_cnt != 16) begin n_fail++; $display("FAIL bp_count_final: got %0d want 16", prev_cnt); end
        stall = 1'b0;
        exp_pc = 32'h10;
        pairs = 0;
        for (int i = 0; i < 30 && pairs < 6; i++) begin
            @(negedge clock);
            if (pair_valid) begin
                n_cmp++; if ({pc_output, first_inst, second_inst} !== {exp_pc, inst_at(exp_pc), inst_at(exp_pc + 32'd4)})
                    begin n_fail++; $display("FAIL bp_drain: got %h %h %h want %h %h %h", pc_output, first_inst, second_inst, exp_pc, inst_at(exp_pc), inst_at(exp_pc + 32'd4)); end
                exp_pc += 32'd8;
                pairs++;
            end
        end
        n_cmp++; if (pairs != 6) begin n_fail++; $display("FAIL bp_drain_count: got %0d pairs want 6", pairs); end
    endtask

    task automatic test_unaligned_branch();
        bit ok;
        branch_taken = 1'b1; branch_target = 32'h0000_0128;
        @(negedge clock);
        branch_taken = 1'b0;
        n_cmp++; if ({pair_valid, first_inst, second_inst} !== 65'h0) begin n_fail++; $display("FAIL ub_clear: got %0b %h %h want 0 0 0", pair_valid, first_inst, second_inst); end
        n_cmp++; if (int'(dut.count) != 0) begin n_fail++; $display("FAIL ub_empty: got %0d want 0", int'(dut.count)); end
        wait_req(10, ok);
        n_cmp++; if ({ok, ls_rd_addr} !== {1'b1, 15'h0120}) begin n_fail++; $display("FAIL ub_req: got %0b %h want 1 0120", ok, ls_rd_addr); end
        wait_pair(10, ok);
        n_cmp++; if ({ok, pc_output, first_inst, second_inst} !== {1'b1, 32'h128, 32'h128, 32'h12C})
            begin n_fail++; $display("FAIL ub_pair0: got %0b %h %h %h want 1 128 128 12c", ok, pc_output, first_inst, second_inst); end
        wait_pair(10, ok);
        n_cmp++; if ({ok, pc_output, first_inst, second_inst} !== {1'b1, 32'h130, 32'h130, 32'h134})
            begin n_fail++; $display("FAIL ub_pair1: got %0b %h %h %h want 1 130 130 134", ok, pc_output, first_inst, second_inst); end
    endtask

    task automatic test_branch_wait();
        bit found, ok;
        int gap;
        resp_delay = 3;
        branch_taken = 1'b1; branch_target = 32'h0000_0040;
        @(negedge clock);
        branch_taken = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            if (ls_rd_req && ls_rd_addr == 15'h0040) found = 1'b1;
        end
        n_cmp++; if (found !== 1'b1) begin n_fail++; $display("FAIL bw_req40: got %0b want 1", found); end
        branch_taken = 1'b1; branch_target = 32'h0000_0200;
        @(negedge clock);
        branch_taken = 1'b0;
        gap = 1; ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clock);
            gap++;
            ok = ls_rd_req;
        end
        n_cmp++; if ({ok, ls_rd_addr} !== {1'b1, 15'h0200}) begin n_fail++; $display("FAIL bw_req_target: got %0b %h want 1 0200", ok, ls_rd_addr); end
        n_cmp++; if (gap != 5) begin n_fail++; $display("FAIL bw_req_gap: got %0d cycles want 5", gap); end
        wait_pair(20, ok);
        n_cmp++; if ({ok, pc_output, first_inst, second_inst} !== {1'b1, 32'h200, 32'h200, 32'h204})
            begin n_fail++; $display("FAIL bw_pair: got %0b %h %h %h want 1 200 200 204", ok, pc_output, first_inst, second_inst); end
    endtask

    task automatic test_simultaneous();
        bit ok;
        resp_en = 1'b0; resp_delay = 0;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        n_cmp++; if ({ls_rd_req, ls_rd_addr} !== {1'b1, 15'h0}) begin n_fail++; $display("FAIL sim_req0: got %0b %h want 1 0000", ls_rd_req, ls_rd_addr); end
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0400;
        man_valid = 1'b1; man_data = {4{32'hDEADBEEF}};
        @(negedge clock);
        stall = 1'b0; branch_taken = 1'b0; man_valid = 1'b0;
        n_cmp++; if ({pair_valid, ls_rd_req} !== 2'b00) begin n_fail++; $display("FAIL sim_clear: got pv=%0b req=%0b want 0 0", pair_valid, ls_rd_req); end
        n_cmp++; if (int'(dut.count) != 0) begin n_fail++; $display("FAIL sim_dropped: got %0d words want 0", int'(dut.count)); end
        @(negedge clock);
        n_cmp++; if ({ls_rd_req, ls_rd_addr} !== {1'b1, 15'h0400}) begin n_fail++; $display("FAIL sim_run_req: got %0b %h want 1 0400", ls_rd_req, ls_rd_addr); end
        man_valid = 1'b1; man_data = quad_at(32'h400);
        @(negedge clock);
        man_valid = 1'b0; resp_en = 1'b1;
        wait_pair(10, ok);
        n_cmp++; if ({ok, pc_output, first_inst, second_inst} !== {1'b1, 32'h400, 32'h400, 32'h404})
            begin n_fail++; $display("FAIL sim_pair: got %0b %h %h %h want 1 400 400 404", ok, pc_output, first_inst, second_inst); end
    endtask

    task automatic test_wrap();
        logic [14:0] reqs [2];
        logic [31:0] pcs [3], fs [3], ss [3];
        logic [31:0] exp_pc [3], exp_f [3], exp_s [3];
        int nreq, npair;
        exp_pc = '{32'h7FF0, 32'h7FF8, 32'h8000};
        exp_f  = '{32'h7FF0, 32'h7FF8, 32'h11111111};
        exp_s  = '{32'h7FF4, 32'h7FFC, 32'h22222222};
        branch_taken = 1'b1; branch_target = 32'h0000_7FF0;
        @(negedge clock);
        branch_taken = 1'b0;
        nreq = 0; npair = 0;
        for (int i = 0; i < 40 && (nreq < 2 || npair < 3); i++) begin
            @(negedge clock);
            if (ls_rd_req && nreq < 2) begin reqs[nreq] = ls_rd_addr; nreq++; end
            if (pair_valid && npair < 3) begin pcs[npair] = pc_output; fs[npair] = first_inst; ss[npair] = second_inst; npair++; end
        end
        n_cmp++; if (nreq != 2 || npair != 3) begin n_fail++; $display("FAIL wrap_counts: got %0d reqs %0d pairs want 2 3", nreq, npair); end
        if (nreq == 2) begin
            n_cmp++; if (reqs[0] !== 15'h7FF0) begin n_fail++; $display("FAIL wrap_req0: got %h want 7ff0", reqs[0]); end
            n_cmp++; if (reqs[1] !== 15'h0000) begin n_fail++; $display("FAIL wrap_req1: got %h want 0000", reqs[1]); end
        end
        for (int i = 0; i < npair; i++) begin
            n_cmp++; if ({pcs[i], fs[i], ss[i]} !== {exp_pc[i], exp_f[i], exp_s[i]})
                begin n_fail++; $display("FAIL wrap_pair%0d: got %h %h %h want %h %h %h", i, pcs[i], fs[i], ss[i], exp_pc[i], exp_f[i], exp_s[i]); end
        end
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        resp_en = 1'b0;
        wait_req(10, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rw_req: got %0b want 1", ok); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if ({pair_valid, ls_rd_req, first_inst, second_inst, pc_output} !== 98'h0)
            begin n_fail++; $display("FAIL rw_async: got %0b %0b %h %h %h want all 0", pair_valid, ls_rd_req, first_inst, second_inst, pc_output); end
        @(negedge clock);
        man_valid = 1'b1; man_data = {4{32'h0BAD0BAD}};
        reset = 1'b1;
        @(negedge clock);
        man_valid = 1'b0;
        n_cmp++; if ({ls_rd_req, ls_rd_addr} !== {1'b1, 15'h0}) begin n_fail++; $display("FAIL rw_first_req: got %0b %h want 1 0000", ls_rd_req, ls_rd_addr); end
        n_cmp++; if (int'(dut.count) != 0) begin n_fail++; $display("FAIL rw_ignored: got %0d words want 0", int'(dut.count)); end
        man_valid = 1'b1; man_data = quad_at(32'h0);
        @(negedge clock);
        man_valid = 1'b0;
        wait_pair(10, ok);
        n_cmp++; if ({ok, pc_output, first_inst, second_inst} !== {1'b1, 32'h0, 32'h11111111, 32'h22222222})
            begin n_fail++; $display("FAIL rw_pair: got %0b %h %h %h want 1 0 11111111 22222222", ok, pc_output, first_inst, second_inst); end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        man_valid = 1'b0; man_data = '0; resp_en = 1'b1; resp_delay = 0;
        test_reset();
        test_fill();
        test_backpressure();
        test_unaligned_branch();
        test_branch_wait();
        test_simultaneous();
        test_wrap();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_prefetch_buffer.md
INST_PREFETCH_BUFFER -- requirements
Module: inst_prefetch_buffer

Interface
REQ-001 The module SHALL have parameter DEPTH, default 16, giving the instruction FIFO depth in 32-bit words; the legal values are powers of two, 8 or greater.
REQ-002 Port `clock`: input, 1 bit. The single clock; every register updates on its rising edge.
REQ-003 Port `reset`: input, 1 bit. Reset is asynchronous and active-low.
REQ-004 Port `ls_rd_req`: output, 1 bit. One-cycle pulse requesting one quadword from local store.
REQ-005 Port `ls_rd_addr`: output, [0:14]. Byte address of the requested quadword. It is always 16-byte aligned, so bits [11:14] are 0.
REQ-006 Port `ls_rd_valid`: input, 1 bit. Local store read response strobe.
REQ-007 Port `ls_rd_data`: input, [0:127]. Response data: four instructions, with word 0 in bits [0:31].
REQ-008 Port `stall`: input, 1 bit. Decode stall; the pair currently presented is held.
REQ-009 Port `branch_taken`: input, 1 bit. Redirect request from the odd pipe.
REQ-010 Port `branch_target`: input, [0:31]. Redirect byte address.
REQ-011 Port `first_inst`: output, [0:31]. Older instruction of the pair presented to decode.
REQ-012 Port `second_inst`: output, [0:31]. Younger instruction of the pair.
REQ-013 Port `pair_valid`: output, 1 bit. First_inst and second_inst are valid.
REQ-014 Port `pc_output`: output, [0:31]. Byte address of first_inst.

Function
REQ-015 The block SHALL hold a circular FIFO of DEPTH words, with head and tail pointers and a count that ranges from 0 to DEPTH.
REQ-016 The fetch FSM SHALL have the states RUN, WAIT and DISCARD, with at most one local-store request outstanding at any time.
REQ-017 In RUN, with no branch_taken and count <= DEPTH-4, the block SHALL pulse ls_rd_req with ls_rd_addr = fetch_pc[17:31] and move to WAIT.
REQ-018 In WAIT, when ls_rd_valid is asserted, the block SHALL push the response words skip..3 in order, clear skip, add 16 to fetch_pc modulo 2^32, and return to RUN.
REQ-019 ls_rd_addr SHALL wrap from 0x7FF0 to 0x0000 without any special handling.
REQ-020 Output update SHALL follow these rules:
- When stall = 0 and count >= 2: pop two words, register them to first_inst and second_inst, set pc_output = head_pc, add 8 to head_pc, and set pair_valid = 1.
- When stall = 0 and count < 2: set pair_valid = 0 and first_inst = second_inst = 0.
- When stall = 1: hold all outputs and pop nothing.
REQ-021 A push and a pop in the same cycle SHALL both take effect, with count updated by the net change.
REQ-022 The block SHALL never pop more words than count holds or push more words than the free space; the DEPTH-4 issue threshold guarantees room for any response.
REQ-023 branch_taken = 1 SHALL take priority over stall and over every other event. In the cycle it is asserted:
- Empty the FIFO and clear pair_valid, first_inst and second_inst.
- Set fetch_pc = branch_target & 0xFFFFFFF0, head_pc = branch_target & 0xFFFFFFFC, and skip = branch_target[28:29].
REQ-024 branch_taken during WAIT without ls_rd_valid SHALL move the FSM to DISCARD.
REQ-025 branch_taken in the same cycle as ls_rd_valid SHALL drop that response and move the FSM to RUN.
REQ-026 In DISCARD, the next ls_rd_valid SHALL be dropped and the FSM SHALL move to RUN.
REQ-027 branch_taken during DISCARD SHALL update the target registers and leave the FSM in DISCARD.
REQ-028 branch_target bits [30:31] SHALL be ignored.
REQ-029 ls_rd_valid received in RUN SHALL be ignored.

Reset
REQ-030 While reset = 0, the block SHALL asynchronously force:
- state RUN;
- fetch_pc, head_pc, skip, count and both FIFO pointers to 0;
- pair_valid, ls_rd_req, first_inst, second_inst and pc_output to 0.
REQ-031 The first ls_rd_req SHALL occur in the first clock edge after reset deasserts, with ls_rd_addr = 0x0000.
REQ-032 Reset asserted in WAIT or DISCARD SHALL abandon the outstanding request; a response arriving after reset deasserts SHALL be ignored as a RUN-state response.

Verification
REQ-033 The bench SHALL cover sequential fill: release reset, then return 0x11111111/22222222/33333333/44444444 for address 0x0000 one cycle after each request. Required response: pairs (0x11111111, 0x22222222) with pc_output = 0 and then (0x33333333, 0x44444444) with pc_output = 8, and the next request at 0x0010.
REQ-034 The bench SHALL cover backpressure: hold stall = 1 for 20 cycles with DEPTH = 16. Required response: the outputs stay constant, requests stop when count exceeds 12, count never exceeds 16, and no word is lost after stall is released.
REQ-035 The bench SHALL cover an unaligned branch: branch_taken with branch_target = 0x00000128. Required response: the FIFO is emptied, pair_valid = 0 the next cycle, the request goes to 0x0120, and the first pair is words 2 and 3 of that quadword with pc_output = 0x128.
REQ-036 The bench SHALL cover a branch during WAIT: branch_taken while a request to 0x0040 is outstanding. Required response: the late 0x0040 data is discarded and the next request goes to the target quadword.
REQ-037 The bench SHALL cover simultaneous events: stall = 1, branch_taken = 1 and ls_rd_valid = 1 in the same cycle. Required response: the branch wins, the response is dropped, and the FSM is in RUN.
REQ-038 The bench SHALL cover address wrap: branch_target = 0x00007FF0. Required response: requests go to 0x7FF0 and then 0x0000, with pc_output continuing 0x7FF0, 0x7FF8, 0x8000.
